// File: rtl/twi_ctrl_if.sv
// ============================================================================
// twi_ctrl_if : twiddle-set handshake bundle between twi_ctrl and the
//               butterfly datapath (valid/ready plus address, bank, stage).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface twi_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic              twi_valid;
  logic              twi_ready;
  logic [ADDR_W-1:0] twi_addr;
  logic              BN_wire;
  logic [1:0]        stage_idx;

  modport master (
    output twi_valid,
    output twi_addr,
    output BN_wire,
    output stage_idx,
    input  twi_ready
  );

  modport slave (
    input  twi_valid,
    input  twi_addr,
    input  BN_wire,
    input  stage_idx,
    output twi_ready
  );
endinterface

`default_nettype wire

// File: rtl/twi_ctrl.sv
// ============================================================================
// twi_ctrl : twiddle-factor sequencer for the radix-16 memory-based FFT.
//            Optional one-cycle inter-stage bubble: TWI_CTRL_STAGE_GAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module twi_ctrl #(
  parameter int ADDR_W = 10,
  parameter int GROUPS = 1024,
  parameter int STAGES = 4
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  input  wire logic   start,
  input  wire logic   abort,
  output logic        busy,
  output logic        done,
  twi_ctrl_if.master  twi
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [ADDR_W-1:0] G_LAST = ADDR_W'(GROUPS - 1);
  localparam logic [1:0]        S_LAST = 2'(STAGES - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] g_q, g_d;
  logic [1:0]        s_q, s_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              bn_q, bn_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [ADDR_W-1:0] g_inc;
  logic              xfer;

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    s_d     = s_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    bn_d    = bn_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    g_inc   = g_q + 1'b1;
    xfer    = valid_q && twi.twi_ready;

    // abort outranks both a pending transfer and the DONE pulse
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      g_d     = '0;
      s_d     = '0;
      valid_d = 1'b0;
      addr_d  = '0;
      bn_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            state_d = RUN;
            g_d     = '0;
            s_d     = '0;
            valid_d = 1'b1;
            addr_d  = '0;
            bn_d    = 1'b0;
            busy_d  = 1'b1;
          end
        end
        RUN: begin
          if (xfer) begin
            if (g_q != G_LAST) begin
              g_d    = g_inc;
              addr_d = g_inc << {s_q, 2'b00};
              bn_d   = ^g_inc;
            end else if (s_q == S_LAST) begin
              state_d = DONE;
              valid_d = 1'b0;
              done_d  = 1'b1;
            end else begin
              // first group of the next stage always maps to address 0, bank 0
              g_d    = '0;
              s_d    = s_q + 1'b1;
              addr_d = '0;
              bn_d   = 1'b0;
`ifdef TWI_CTRL_STAGE_GAP_EN
              state_d = GAP;
              valid_d = 1'b0;
`endif
            end
          end
        end
        GAP: begin
          state_d = RUN;
          valid_d = 1'b1;
        end
        DONE: begin
          state_d = IDLE;
          busy_d  = 1'b0;
          g_d     = '0;
          s_d     = '0;
          addr_d  = '0;
          bn_d    = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      g_q     <= '0;
      s_q     <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      bn_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      s_q     <= s_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      bn_q    <= bn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign twi.twi_valid = valid_q;
  assign twi.twi_addr  = addr_q;
  assign twi.BN_wire   = bn_q;
  assign twi.stage_idx = s_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

`default_nettype wire

// File: tb/tb_twi_ctrl.sv
// ============================================================================
// tb_twi_ctrl : scoreboard bench for twi_ctrl on three parameter sets
//               (default 1024x4, 16x2 and 16x4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_twi_ctrl;

`ifdef TWI_CTRL_STAGE_GAP_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic tb_start, tb_abort, tb_ready;
  int   sel;

  twi_ctrl_if #(.ADDR_W(10)) if_d ();
  twi_ctrl_if #(.ADDR_W(4))  if_b ();
  twi_ctrl_if #(.ADDR_W(4))  if_g ();

  logic st_d, st_b, st_g, ab_d, ab_b, ab_g;
  logic busy_d, busy_b, busy_g, done_d, done_b, done_g;

  assign st_d = (sel == 0) && tb_start;
  assign st_b = (sel == 1) && tb_start;
  assign st_g = (sel == 2) && tb_start;
  assign ab_d = (sel == 0) && tb_abort;
  assign ab_b = (sel == 1) && tb_abort;
  assign ab_g = (sel == 2) && tb_abort;
  assign if_d.twi_ready = (sel == 0) && tb_ready;
  assign if_b.twi_ready = (sel == 1) && tb_ready;
  assign if_g.twi_ready = (sel == 2) && tb_ready;

  twi_ctrl #(.ADDR_W(10), .GROUPS(1024), .STAGES(4)) dut_d (
    .clk(clk), .rst_n(rst_n), .start(st_d), .abort(ab_d),
    .busy(busy_d), .done(done_d), .twi(if_d)
  );
  twi_ctrl #(.ADDR_W(4), .GROUPS(16), .STAGES(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(st_b), .abort(ab_b),
    .busy(busy_b), .done(done_b), .twi(if_b)
  );
  twi_ctrl #(.ADDR_W(4), .GROUPS(16), .STAGES(4)) dut_g (
    .clk(clk), .rst_n(rst_n), .start(st_g), .abort(ab_g),
    .busy(busy_g), .done(done_g), .twi(if_g)
  );

  logic m_valid, m_bn, m_busy, m_done;
  int   m_addr, m_stg;

  always_comb begin
    m_valid = 1'b0; m_bn = 1'b0; m_busy = 1'b0; m_done = 1'b0;
    m_addr  = 0;    m_stg = 0;
    case (sel)
      0: begin
        m_valid = if_d.twi_valid; m_bn = if_d.BN_wire; m_addr = int'(if_d.twi_addr);
        m_stg = int'(if_d.stage_idx); m_busy = busy_d; m_done = done_d;
      end
      1: begin
        m_valid = if_b.twi_valid; m_bn = if_b.BN_wire; m_addr = int'(if_b.twi_addr);
        m_stg = int'(if_b.stage_idx); m_busy = busy_b; m_done = done_b;
      end
      default: begin
        m_valid = if_g.twi_valid; m_bn = if_g.BN_wire; m_addr = int'(if_g.twi_addr);
        m_stg = int'(if_g.stage_idx); m_busy = busy_g; m_done = done_g;
      end
    endcase
  end

  typedef struct {
    int addr;
    int bn;
    int stg;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_xfer  = 0;
  int   n_done  = 0;

  // Scoreboard monitor: every accepted transfer is compared against the
  // queue head; a stall must hold all outputs into the following cycle.
  initial begin
    exp_t e;
    logic p_stall;
    int   p_addr, p_bn, p_stg;
    p_stall = 1'b0; p_addr = 0; p_bn = 0; p_stg = 0;
    forever begin
      @(negedge clk);
      if (p_stall && rst_n) begin
        n_tests++;
        if (m_valid !== 1'b1 || m_addr != p_addr || int'(m_bn) != p_bn || m_stg != p_stg) begin
          n_fail++;
          $display("FAIL stall_hold: got v=%0b a=%0d bn=%0b s=%0d, want v=1 a=%0d bn=%0d s=%0d",
                   m_valid, m_addr, m_bn, m_stg, p_addr, p_bn, p_stg);
        end
      end
      p_stall = m_valid && !tb_ready && rst_n;
      p_addr  = m_addr;
      p_bn    = int'(m_bn);
      p_stg   = m_stg;
      if (m_done) n_done++;
      if (m_valid && tb_ready && !tb_abort && rst_n) begin
        n_xfer++;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL xfer_extra: got a=%0d s=%0d, want no transfer", m_addr, m_stg);
        end else begin
          e = exp_q.pop_front();
          if (m_addr != e.addr || int'(m_bn) != e.bn || m_stg != e.stg) begin
            n_fail++;
            if (n_fail < 12)
              $display("FAIL xfer_data: got a=%0d bn=%0b s=%0d, want a=%0d bn=%0d s=%0d",
                       m_addr, m_bn, m_stg, e.addr, e.bn, e.stg);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start();
    tick();
    tb_start = 1'b1;
    tick();
    tb_start = 1'b0;
  endtask

  task automatic push_exp(input int groups, input int stages);
    exp_t e;
    for (int s = 0; s < stages; s++) begin
      for (int g = 0; g < groups; g++) begin
        e.addr = (g * (1 << (4 * s))) % groups;
        e.bn   = $countones(g) % 2;
        e.stg  = s;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic run_to_done(input int c0, input int limit, input bit rnd,
                             output int cyc, output int gaps);
    cyc  = c0;
    gaps = 0;
    while (!m_done && cyc < limit) begin
      if (!m_valid) gaps++;
      if (rnd) tb_ready = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tb_start = 1'b0; tb_abort = 1'b0; tb_ready = 1'b0; sel = 0;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      sel = i;
      #1;
      n_tests++;
      if ({m_valid, m_bn, m_busy, m_done} !== 4'b0 || m_addr != 0 || m_stg != 0) begin
        n_fail++;
        $display("FAIL reset_state[%0d]: got v=%0b bn=%0b busy=%0b done=%0b a=%0d s=%0d, want all 0",
                 i, m_valid, m_bn, m_busy, m_done, m_addr, m_stg);
      end
    end
    sel = 0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_full_transform();
    int x0, d0, cyc, gaps;
    sel = 0; tb_ready = 1'b1;
    exp_q.delete();
    push_exp(1024, 4);
    x0 = n_xfer; d0 = n_done;
    pulse_start();
    n_tests++;
    if (m_busy !== 1'b1 || m_valid !== 1'b1 || m_addr != 0 || m_stg != 0) begin
      n_fail++;
      $display("FAIL first_present: got busy=%0b v=%0b a=%0d s=%0d, want 1 1 0 0",
               m_busy, m_valid, m_addr, m_stg);
    end
    repeat (3) tick();
    n_tests++;
    if (m_addr != 3 || m_bn !== 1'b0 || m_stg != 0) begin
      n_fail++;
      $display("FAIL spot_s0_g3: got a=%0d bn=%0b s=%0d, want a=3 bn=0 s=0", m_addr, m_bn, m_stg);
    end
    repeat (1028 + GAP) tick();
    n_tests++;
    if (m_addr != 112 || m_bn !== 1'b1 || m_stg != 1) begin
      n_fail++;
      $display("FAIL spot_s1_g7: got a=%0d bn=%0b s=%0d, want a=112 bn=1 s=1", m_addr, m_bn, m_stg);
    end
    run_to_done(1032 + GAP, 6000, 1'b0, cyc, gaps);
    n_tests++;
    if (cyc != 4097 + 3 * GAP) begin
      n_fail++;
      $display("FAIL full_done_cycle: got %0d, want %0d", cyc, 4097 + 3 * GAP);
    end
    tick();
    n_tests++;
    if (n_xfer - x0 != 4096 || n_done - d0 != 1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL full_counts: got xfers=%0d dones=%0d left=%0d, want 4096 1 0",
               n_xfer - x0, n_done - d0, exp_q.size());
    end
    n_tests++;
    if (m_busy !== 1'b0 || m_done !== 1'b0) begin
      n_fail++;
      $display("FAIL full_busy_drop: got busy=%0b done=%0b, want 0 0", m_busy, m_done);
    end
  endtask

  task automatic test_backpressure();
    int x0, d0, cyc, gaps;
    sel = 1;
    exp_q.delete();
    push_exp(16, 2);
    x0 = n_xfer; d0 = n_done;
    tb_ready = 1'b0;
    pulse_start();
    run_to_done(1, 2000, 1'b1, cyc, gaps);
    tb_ready = 1'b1;
    repeat (3) tick();
    n_tests++;
    if (cyc >= 2000 || n_xfer - x0 != 32 || n_done - d0 != 1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_counts: got cyc=%0d xfers=%0d dones=%0d left=%0d, want <2000 32 1 0",
               cyc, n_xfer - x0, n_done - d0, exp_q.size());
    end
  endtask

  task automatic test_start_while_busy();
    int x0, d0, cyc, gaps;
    sel = 1; tb_ready = 1'b1;
    exp_q.delete();
    push_exp(16, 2);
    x0 = n_xfer; d0 = n_done;
    pulse_start();
    repeat (4) tick();
    tb_start = 1'b1;
    tick();
    tb_start = 1'b0;
    run_to_done(6, 500, 1'b0, cyc, gaps);
    repeat (3) tick();
    n_tests++;
    if (cyc != 33 + GAP || n_xfer - x0 != 32 || n_done - d0 != 1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL start_busy: got cyc=%0d xfers=%0d dones=%0d left=%0d, want %0d 32 1 0",
               cyc, n_xfer - x0, n_done - d0, exp_q.size(), 33 + GAP);
    end
  endtask

  task automatic test_abort();
    int x0, d0;
    sel = 1; tb_ready = 1'b1;
    exp_q.delete();
    push_exp(16, 2);
    x0 = n_xfer; d0 = n_done;
    pulse_start();
    repeat (21 + GAP) tick();
    n_tests++;
    if (m_stg != 1 || m_valid !== 1'b1 || n_xfer - x0 != 21) begin
      n_fail++;
      $display("FAIL abort_setup: got s=%0d v=%0b xfers=%0d, want 1 1 21", m_stg, m_valid, n_xfer - x0);
    end
    tb_abort = 1'b1;
    tick();
    tb_abort = 1'b0;
    n_tests++;
    if (m_valid !== 1'b0 || m_busy !== 1'b0 || m_done !== 1'b0 || m_stg != 0 || m_addr != 0) begin
      n_fail++;
      $display("FAIL abort_idle: got v=%0b busy=%0b done=%0b s=%0d a=%0d, want all 0",
               m_valid, m_busy, m_done, m_stg, m_addr);
    end
    repeat (4) tick();
    n_tests++;
    if (n_done - d0 != 0 || n_xfer - x0 != 21 || m_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_after: got dones=%0d xfers=%0d busy=%0b, want 0 21 0",
               n_done - d0, n_xfer - x0, m_busy);
    end
    exp_q.delete();
    tb_start = 1'b1; tb_abort = 1'b1;
    tick();
    tb_start = 1'b0; tb_abort = 1'b0;
    tick();
    n_tests++;
    if (m_busy !== 1'b0 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_start_idle: got busy=%0b v=%0b, want 0 0", m_busy, m_valid);
    end
  endtask

  task automatic test_reset_midrun();
    int x0, d0, cyc, gaps;
    sel = 1; tb_ready = 1'b1;
    exp_q.delete();
    push_exp(16, 2);
    x0 = n_xfer; d0 = n_done;
    pulse_start();
    repeat (5) tick();
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({m_valid, m_bn, m_busy, m_done} !== 4'b0 || m_addr != 0 || m_stg != 0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got v=%0b bn=%0b busy=%0b done=%0b a=%0d s=%0d, want all 0",
               m_valid, m_bn, m_busy, m_done, m_addr, m_stg);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    n_tests++;
    if (n_xfer - x0 != 5 || n_done - d0 != 0) begin
      n_fail++;
      $display("FAIL rst_mid_counts: got xfers=%0d dones=%0d, want 5 0", n_xfer - x0, n_done - d0);
    end
    exp_q.delete();
    push_exp(16, 2);
    x0 = n_xfer; d0 = n_done;
    pulse_start();
    n_tests++;
    if (m_valid !== 1'b1 || m_addr != 0 || m_stg != 0) begin
      n_fail++;
      $display("FAIL rst_restart: got v=%0b a=%0d s=%0d, want 1 0 0", m_valid, m_addr, m_stg);
    end
    run_to_done(1, 500, 1'b0, cyc, gaps);
    repeat (3) tick();
    n_tests++;
    if (cyc != 33 + GAP || n_xfer - x0 != 32 || n_done - d0 != 1) begin
      n_fail++;
      $display("FAIL rst_rerun: got cyc=%0d xfers=%0d dones=%0d, want %0d 32 1",
               cyc, n_xfer - x0, n_done - d0, 33 + GAP);
    end
  endtask

  task automatic test_stage_gap();
    int x0, d0, cyc, gaps;
    sel = 2; tb_ready = 1'b1;
    exp_q.delete();
    push_exp(16, 4);
    x0 = n_xfer; d0 = n_done;
    pulse_start();
    run_to_done(1, 500, 1'b0, cyc, gaps);
    n_tests++;
    if (cyc != 65 + 3 * GAP || gaps != 3 * GAP) begin
      n_fail++;
      $display("FAIL gap_timing: got done_cyc=%0d bubbles=%0d, want %0d %0d",
               cyc, gaps, 65 + 3 * GAP, 3 * GAP);
    end
    repeat (3) tick();
    n_tests++;
    if (n_xfer - x0 != 64 || n_done - d0 != 1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL gap_counts: got xfers=%0d dones=%0d left=%0d, want 64 1 0",
               n_xfer - x0, n_done - d0, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_full_transform();
    test_backpressure();
    test_start_while_busy();
    test_abort();
    test_reset_midrun();
    test_stage_gap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/twi_ctrl.md
# twi_ctrl

Twiddle-factor sequencer for the radix-16 memory-based FFT. After a start pulse it walks every stage and butterfly group, producing the twiddle ROM address and the bank-select bit (`BN_wire`) that drive the two-bank twiddle mux. It hands each twiddle set to the butterfly datapath over a valid/ready handshake and pulses `done` after the last group of the last stage.

## Interface
- `ADDR_W`, 10: twiddle ROM address width; GROUPS must equal 2**ADDR_W.
- `GROUPS`, 1024: butterfly groups per stage (16384/16).
- `STAGES`, 4: FFT stages per transform; 1..4.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: one-cycle request to begin a transform; ignored unless idle.
- `abort` in 1: synchronous cancel of the transform in progress.
- `twi_ready` in 1: butterfly datapath accepts the current twiddle set.
- `twi_valid` out 1: twiddle address, bank and stage outputs are valid.
- `twi_addr` out ADDR_W: twiddle ROM address.
- `BN_wire` out 1: twiddle bank select; 1 selects bank 1 (b1), 0 selects bank 0 (b0).
- `stage_idx` out 2: current stage number, 0..STAGES-1.
- `busy` out 1: high from the cycle after an accepted start until return to IDLE.
- `done` out 1: one-cycle pulse at transform completion.

## Operation
- **FSM states:** IDLE, RUN, GAP, DONE.
  - IDLE → RUN on `start`.
  - RUN → GAP or DONE after the last handshake of a stage.
  - GAP → RUN after one cycle.
  - DONE → IDLE after one cycle.
- **Counters:** group counter g (ADDR_W bits) and stage counter s (2 bits); both are cleared on entry to RUN from IDLE.
- **Handshake:** a transfer occurs when `twi_valid` && `twi_ready`. On a transfer:
  - g increments.
  - At g == GROUPS-1, g wraps to 0 and s increments.
  - At s == STAGES-1 with g == GROUPS-1, the FSM enters DONE.
- **Stall:** while `twi_valid` is high and `twi_ready` is low, all outputs hold their values.
- **Address:** `twi_addr` = (g << (4*s)) truncated to ADDR_W bits. With the defaults:
  - stage 0 → g
  - stage 1 → g[5:0],4'b0
  - stage 2 → g[1:0],8'b0
  - stage 3 → 0
- **Bank:** `BN_wire` = XOR-reduction of g (digit-parity bank assignment). It is registered together with `twi_addr`.
- `stage_idx` = s.
- **start while busy:** ignored; it has no effect on counters or outputs.
- **abort:** in RUN, GAP or DONE, the next state is IDLE. In that same next cycle `twi_valid`, `busy` and `done` are low and the counters are cleared. abort has priority over a same-cycle transfer and over DONE. abort in IDLE has no effect.
- **start and abort together in IDLE:** abort wins and the FSM stays in IDLE.
- **Reset** (async, at any time, including mid-transform):
  - FSM enters IDLE.
  - `twi_valid`=0, `twi_addr`=0, `BN_wire`=0, `stage_idx`=0, `busy`=0, `done`=0.
  - No `done` pulse is produced.

## Timing
- All outputs come straight from registers; there is no combinational path from any input to any output.
- If `start` is sampled high in IDLE at edge N, then from edge N+1: `busy`=1, `twi_valid`=1, `twi_addr`=0, `stage_idx`=0.
- After a transfer at edge k, the next address is presented from edge k. Throughput is one transfer per cycle when `twi_ready` is held high.
- `done` is high for exactly one cycle, starting at the edge after the final transfer. `busy` is high through the DONE cycle and drops one cycle after `done`.
- Start-to-done with `twi_ready` constant 1 is STAGES*GROUPS+1 cycles, plus STAGES-1 when the gap feature is compiled in.
- A back-to-back `start` is accepted no earlier than the cycle after `busy` falls.

## Configuration
- **`TWI_CTRL_STAGE_GAP_EN` defined:** after the last transfer of every stage except the final one, the FSM spends one cycle in GAP with `twi_valid`=0, giving the datapath write-back turnaround. The outputs during GAP are:
  - `twi_addr`=0
  - `BN_wire`=0
  - `stage_idx` = the new stage number
- **Not defined:** the GAP state is unreachable and stages run back-to-back with no bubble.

## Test plan
- **Reset mid-run:** GROUPS=16, ADDR_W=4, STAGES=2; start, assert `rst_n`=0 after 5 transfers → all outputs go to 0 immediately, no `done` pulse; a subsequent start begins again at addr 0, stage 0.
- **Full transform:** defaults, `twi_ready`=1, one start → exactly 4096 transfers and `done` on cycle 4097 after start. Check addr/`BN_wire` spot values:
  - stage 0, g=3 → addr 3, BN 0
  - stage 1, g=7 → addr 112, BN 1
  - stage 3 → addr 0 throughout
- **Backpressure:** GROUPS=16, ADDR_W=4, STAGES=2; toggle `twi_ready` pseudo-randomly → outputs stable during stalls, exactly 32 transfers in order, `done` once.
- **Start while busy / abort:**
  - Start pulsed mid-run → ignored, transfer count unchanged.
  - abort at stage 1, g=5 → IDLE next cycle, `twi_valid`=0, no `done`.
  - abort and start together in IDLE → stays IDLE.
- **Gap feature:** with `TWI_CTRL_STAGE_GAP_EN` defined, STAGES=4, GROUPS=16, ADDR_W=4 → exactly 3 cycles with `twi_valid`=0, each between stages, and `done` at start+68. Without the macro, `done` at start+65.
